// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared MDU op encoding and latency constants
// Purpose: op type shared by the decoder, the hazard unit and the MDU,
//          plus default latencies and op-class helpers.
// Ports:   none (package)
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_t;

  localparam int MDU_WIDTH       = 32;
  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  // Ops that occupy the unit for several cycles before HI/LO update.
  function automatic logic mdu_is_long(input mdu_op_t op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  function automatic logic mdu_is_div(input mdu_op_t op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// rtl/mdu_arith.sv - combinational multiply/divide datapath
// Purpose: computes the HI/LO result of a mult/multu/div/divu in one shot;
//          the controller only models the latency.
// Ports:
//   op          in   mdu_op_t  operation select
//   rs, rt      in   WIDTH     operands (rs = dividend / multiplicand)
//   res_hi      out  WIDTH     product high half or remainder
//   res_lo      out  WIDTH     product low half or quotient
//   div_by_zero out  1         div/divu with rt == 0
module mdu_arith
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  mdu_op_t          op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div_by_zero
);

  logic [2*WIDTH-1:0] prod_u;
  logic [2*WIDTH-1:0] prod_s;
  logic               signed_div;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   den;
  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH-1:0]   r_mag;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  // The low 2*WIDTH bits of the product of sign-extended operands are the
  // signed product, so both flavours share an unsigned multiplier form.
  assign prod_u = {{WIDTH{1'b0}}, rs} * {{WIDTH{1'b0}}, rt};
  assign prod_s = {{WIDTH{rs[WIDTH-1]}}, rs} * {{WIDTH{rt[WIDTH-1]}}, rt};

  // Signed division is done on magnitudes. The magnitude of the most
  // negative value fits unsigned, so MIN / -1 naturally yields MIN, rem 0.
  assign signed_div  = (op == MDU_DIV);
  assign a_neg       = signed_div & rs[WIDTH-1];
  assign b_neg       = signed_div & rt[WIDTH-1];
  assign a_mag       = a_neg ? -rs : rs;
  assign b_mag       = b_neg ? -rt : rt;
  assign div_by_zero = mdu_is_div(op) && (rt == '0);
  // Substitute a divisor of 1 so the datapath never divides by zero;
  // the controller drops the result in that case.
  assign den         = (rt == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
  assign q_mag       = a_mag / den;
  assign r_mag       = a_mag % den;
  assign quot        = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem         = a_neg ? -r_mag : r_mag;

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (op)
      MDU_MULT:           {res_hi, res_lo} = prod_s;
      MDU_MULTU:          {res_hi, res_lo} = prod_u;
      MDU_DIV, MDU_DIVU: begin
        res_hi = rem;
        res_lo = quot;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multiply/divide sequencer owning HI/LO
// Purpose: accepts MDU ops from E, holds the result for a fixed latency,
//          writes HI/LO on completion and requests pipeline stalls.
// Ports:
//   clk        in   1         core clock
//   reset      in   1         asynchronous active-low reset
//   start      in   1         E-stage MDU op valid
//   op         in   mdu_op_t  operation
//   rs_val     in   WIDTH     forwarded rs operand
//   rt_val     in   WIDTH     forwarded rt operand
//   md_use_d   in   1         D-stage instruction touches the MDU
//   busy       out  1         multi-cycle op in flight
//   stall_req  out  1         combinational stall request
//   hi, lo     out  WIDTH     architectural HI/LO
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int WIDTH       = MDU_WIDTH,
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  mdu_op_t          op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             md_use_d,
  output logic             busy,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] pend_hi, pend_lo;
  logic             pend_wr;
  logic             accept_long, accept_mthi, accept_mtlo, retire;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             div_by_zero;

  mdu_arith #(.WIDTH(WIDTH)) u_arith (
    .op          (op),
    .rs          (rs_val),
    .rt          (rt_val),
    .res_hi      (res_hi),
    .res_lo      (res_lo),
    .div_by_zero (div_by_zero)
  );

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    accept_long = 1'b0;
    accept_mthi = 1'b0;
    accept_mtlo = 1'b0;
    retire      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (mdu_is_long(op)) begin
            accept_long = 1'b1;
            state_n     = S_RUN;
            cnt_n       = mdu_is_div(op) ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
          end else if (op == MDU_MTHI) begin
            accept_mthi = 1'b1;
          end else if (op == MDU_MTLO) begin
            accept_mtlo = 1'b1;
          end
        end
      end
      S_RUN: begin
        // Commands arriving here are ignored; the hazard unit keeps them out.
        if (cnt == '0) begin
          retire  = 1'b1;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept_long) begin
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        // Division by zero leaves HI/LO untouched but still costs the latency.
        pend_wr <= ~div_by_zero;
      end
      if (accept_mthi) hi <= rs_val;
      if (accept_mtlo) lo <= rs_val;
      if (retire && pend_wr) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end
  end

  assign busy      = (state == S_RUN);
  assign stall_req = md_use_d & (busy | (start & mdu_is_long(op)));

  a_no_start_while_busy: assert property (
    @(posedge clk) disable iff (!reset) !(start && busy)
  );

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - scoreboard testbench for mdu_ctrl
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  mdu_op_t     op = MDU_NONE;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        md_use_d = 1'b0;
  logic        busy, stall_req;
  logic [31:0] hi, lo;

  mdu_ctrl #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .md_use_d  (md_use_d),
    .busy      (busy),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: a result is presented on the cycle busy falls.
  exp_t mon_e;
  logic prev_busy = 1'b0;
  int   bcnt = 0;
  always @(negedge clk) begin
    if (!reset) begin
      prev_busy = 1'b0;
      bcnt      = 0;
    end else begin
      if (busy) begin
        bcnt++;
      end else if (prev_busy) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: hi=0x%08h lo=0x%08h with empty scoreboard", hi, lo);
        end else begin
          mon_e = sb.pop_front();
          chk({mon_e.name, "_hi"}, hi, mon_e.hi);
          chk({mon_e.name, "_lo"}, lo, mon_e.lo);
          chk({mon_e.name, "_busy_cycles"}, 32'(bcnt), 32'(mon_e.cycles));
        end
        bcnt = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic issue(input mdu_op_t o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = MDU_NONE;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: busy=%0b after %0d cycles, required 0", name, busy, n);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic run_op(input string name, input mdu_op_t o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi,
                        input logic [31:0] elo, input int ecyc);
    sb.push_back('{hi: ehi, lo: elo, cycles: ecyc, name: name});
    issue(o, a, b);
    wait_idle(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_stall", {31'b0, stall_req}, 32'd0);

    run_op("mult_neg", MDU_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 5);
    run_op("divu_100_7", MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 10);
    run_op("div_overflow", MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 10);

    // Stall behaviour around a MULT issued with a dependent D-stage op.
    sb.push_back('{hi: 32'h0, lo: 32'd12, cycles: 5, name: "mult_stall"});
    @(posedge clk);
    #1;
    start = 1'b1; op = MDU_MULT; rs_val = 32'd3; rt_val = 32'd4; md_use_d = 1'b1;
    #1;
    chk("stall_issue", {31'b0, stall_req}, 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0; op = MDU_NONE;
    for (int i = 1; i <= 5; i++) begin
      chk($sformatf("stall_t%0d", i), {31'b0, stall_req}, 32'd1);
      if (i == 3) begin
        md_use_d = 1'b0;
        #1;
        chk("stall_no_use", {31'b0, stall_req}, 32'd0);
        chk("busy_no_use", {31'b0, busy}, 32'd1);
        md_use_d = 1'b1;
        #1;
      end
      @(posedge clk);
      #1;
    end
    chk("stall_t6", {31'b0, stall_req}, 32'd0);
    md_use_d = 1'b0;
    @(negedge clk);
    #1;

    run_op("div_neg", MDU_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);

    // MTHI/MTLO: immediate, no busy, no stall even with a dependent D-stage op.
    @(posedge clk);
    #1;
    start = 1'b1; op = MDU_MTHI; rs_val = 32'h11; md_use_d = 1'b1;
    #1;
    chk("stall_mthi", {31'b0, stall_req}, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0; op = MDU_NONE; md_use_d = 1'b0;
    chk("mthi_busy", {31'b0, busy}, 32'd0);
    chk("mthi_hi", hi, 32'h11);
    chk("mthi_lo_kept", lo, 32'hFFFFFFFD);
    issue(MDU_MTLO, 32'h22, 32'h0);
    chk("mtlo_busy", {31'b0, busy}, 32'd0);
    chk("mtlo_lo", lo, 32'h22);
    chk("mtlo_hi_kept", hi, 32'h11);

    run_op("divu_zero", MDU_DIVU, 32'd5, 32'd0, 32'h11, 32'h22, 10);
    run_op("multu_max", MDU_MULTU, 32'hFFFFFFFF, 32'd2, 32'h1, 32'hFFFFFFFE, 5);

    // Asynchronous reset in the middle of a DIV discards it.
    issue(MDU_DIV, 32'd50, 32'd5);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("async_reset_busy", {31'b0, busy}, 32'd0);
    chk("async_reset_hi", hi, 32'h0);
    chk("async_reset_lo", lo, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    run_op("mult_after_reset", MDU_MULT, 32'd2, 32'd3, 32'h0, 32'd6, 5);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
